// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// Module   : rv32i_pkg
// Brief    : Shared types for the RV32I core pipeline sequencing logic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_W    = 2'b01,
        FWD_M    = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_controller_if.sv
//------------------------------------------------------------------------------
// Module   : hazard_controller_if
// Brief    : Datapath <-> hazard controller signal bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface hazard_controller_if #(
    parameter int ADW   = 5,
    parameter int CNT_W = 32
);
    import rv32i_pkg::*;

    logic [ADW-1:0]   Rs1D, Rs2D;
    logic [ADW-1:0]   Rs1E, Rs2E, RdE;
    logic             resultsrcE;
    logic             pcsrcE;
    logic [ADW-1:0]   RdM, RdW;
    logic             regwriteM, regwriteW;
    logic             mem_req, mem_ready;

    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE;
    fwd_sel_t         forwardAE, forwardBE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultsrcE, pcsrcE,
        output RdM, RdW, regwriteM, regwriteW, mem_req, mem_ready,
        input  stallF, stallD, stallE, stallM, flushD, flushE,
        input  forwardAE, forwardBE, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultsrcE, pcsrcE,
        input  RdM, RdW, regwriteM, regwriteW, mem_req, mem_ready,
        output stallF, stallD, stallE, stallM, flushD, flushE,
        output forwardAE, forwardBE, mem_err, stall_cnt, flush_cnt
    );

endinterface

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module   : sat_counter
// Brief    : Up-counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int W = 32
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    output logic [W-1:0]      cnt
);

    localparam logic [W-1:0] c_cnt_max = '1;

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : hazard_controller
// Brief    : Stall/flush/forward sequencing for the five-stage RV32I pipeline,
//            with a memory-wait freeze, timeout watchdog and perf counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module hazard_controller #(
    parameter int ADW   = 5,
    parameter int TMO_W = 4,
    parameter int CNT_W = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    hazard_controller_if.slave  hz
);
    import rv32i_pkg::*;

    localparam logic [TMO_W-1:0] c_tmo_max = '1;
    localparam logic [ADW-1:0]   c_x0      = '0;

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_mem_err;

    logic             w_lwstall;
    logic             w_timeout;
    logic             w_freeze;
    logic             w_stallF, w_stallD, w_stallE, w_stallM;
    logic             w_flushD, w_flushE;
    fwd_sel_t         w_fwd_a, w_fwd_b;
    logic [CNT_W-1:0] w_stall_cnt, w_flush_cnt;

    // M beats W: the M-stage value is the younger write to the same register.
    function automatic fwd_sel_t fwd_pick(
        input logic [ADW-1:0] rs,
        input logic           we_m,
        input logic [ADW-1:0] rd_m,
        input logic           we_w,
        input logic [ADW-1:0] rd_w
    );
        if (we_m && (rd_m != c_x0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (we_w && (rd_w != c_x0) && (rd_w == rs)) begin
            return FWD_W;
        end
        return FWD_NONE;
    endfunction

    assign w_lwstall = hz.resultsrcE && (hz.RdE != c_x0) &&
                       ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

    assign w_timeout = (r_state == MEM_WAIT) && !hz.mem_ready &&
                       (r_wait_cnt == c_tmo_max);

    assign w_freeze  = ((r_state == RUN)      && hz.mem_req && !hz.mem_ready) ||
                       ((r_state == MEM_WAIT) && !hz.mem_ready && !w_timeout);

    // State register, wait counter and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_mem_err <= w_timeout;
            if (r_state == MEM_WAIT) begin
                r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    w_state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready || w_timeout) begin
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_stallF = 1'b0;
        w_stallD = 1'b0;
        w_stallE = 1'b0;
        w_stallM = 1'b0;
        w_flushD = 1'b0;
        w_flushE = 1'b0;
        w_fwd_a  = FWD_NONE;
        w_fwd_b  = FWD_NONE;
        if (rst) begin
            w_flushD = 1'b1;
            w_flushE = 1'b1;
        end else begin
            w_fwd_a = fwd_pick(hz.Rs1E, hz.regwriteM, hz.RdM, hz.regwriteW, hz.RdW);
            w_fwd_b = fwd_pick(hz.Rs2E, hz.regwriteM, hz.RdM, hz.regwriteW, hz.RdW);
            if (w_freeze) begin
                // Pending branch/load-use stays in place until the freeze lifts.
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_stallE = 1'b1;
                w_stallM = 1'b1;
            end else begin
                w_stallF = w_lwstall;
                w_stallD = w_lwstall;
                w_flushE = w_lwstall || hz.pcsrcE;
                w_flushD = hz.pcsrcE;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stallF),
        .cnt (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flushE),
        .cnt (w_flush_cnt)
    );

    assign hz.stallF    = w_stallF;
    assign hz.stallD    = w_stallD;
    assign hz.stallE    = w_stallE;
    assign hz.stallM    = w_stallM;
    assign hz.flushD    = w_flushD;
    assign hz.flushE    = w_flushE;
    assign hz.forwardAE = w_fwd_a;
    assign hz.forwardBE = w_fwd_b;
    assign hz.mem_err   = r_mem_err;
    assign hz.stall_cnt = w_stall_cnt;
    assign hz.flush_cnt = w_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_hazard_controller
// Brief    : Randomized and directed bench for hazard_controller against a
//            cycle-level behavioural model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hazard_controller;
    import rv32i_pkg::*;

    localparam int c_adw     = 5;
    localparam int c_tmo_w   = 4;
    localparam int c_cnt_w   = 4;
    localparam int c_tmo_lim = (1 << c_tmo_w) - 1;
    localparam int c_cnt_max = (1 << c_cnt_w) - 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_controller_if #(.ADW(c_adw), .CNT_W(c_cnt_w)) hz ();

    hazard_controller #(.ADW(c_adw), .TMO_W(c_tmo_w), .CNT_W(c_cnt_w)) u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: waiting flag, number of completed wait cycles.
    bit m_valid = 1'b0;
    bit m_wait;
    int m_waited;
    int m_stall;
    int m_flush;
    bit m_err;

    logic obs_stallF, obs_stallM, obs_flushE, obs_mem_err;
    int   obs_stall_cnt, obs_flush_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int fwd_model(input logic [c_adw-1:0] rs);
        if (hz.regwriteM && hz.RdM != 0 && hz.RdM == rs) return 2;
        if (hz.regwriteW && hz.RdW != 0 && hz.RdW == rs) return 1;
        return 0;
    endfunction

    task automatic set_idle();
        rst = 1'b0;
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0;
        hz.RdE = '0; hz.RdM = '0; hz.RdW = '0;
        hz.resultsrcE = 1'b0; hz.pcsrcE = 1'b0;
        hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic rand_inputs(input int ready_odds);
        hz.Rs1D = 5'($urandom_range(0, 3));
        hz.Rs2D = 5'($urandom_range(0, 3));
        hz.Rs1E = 5'($urandom_range(0, 3));
        hz.Rs2E = 5'($urandom_range(0, 3));
        hz.RdE  = 5'($urandom_range(0, 3));
        hz.RdM  = 5'($urandom_range(0, 3));
        hz.RdW  = 5'($urandom_range(0, 3));
        hz.resultsrcE = ($urandom_range(0, 2) == 0);
        hz.regwriteM  = $urandom_range(0, 1) != 0;
        hz.regwriteW  = $urandom_range(0, 1) != 0;
        hz.pcsrcE     = ($urandom_range(0, 3) == 0);
        hz.mem_req    = ($urandom_range(0, 2) == 0);
        hz.mem_ready  = ($urandom_range(0, ready_odds) == 0);
        if (hz.resultsrcE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D))
            hz.pcsrcE = 1'b0;
        rst = ($urandom_range(0, 63) == 0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic cycle();
        int fa, fb;
        bit lw, tmo, frz;
        bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe;
        @(negedge clk);
        fa  = fwd_model(hz.Rs1E);
        fb  = fwd_model(hz.Rs2E);
        lw  = hz.resultsrcE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        tmo = m_wait && !hz.mem_ready && (m_waited == c_tmo_lim);
        frz = (!m_wait && hz.mem_req && !hz.mem_ready) || (m_wait && !hz.mem_ready && !tmo);
        if (rst) begin
            {e_sf, e_sd, e_se, e_sm} = 4'b0000;
            {e_fd, e_fe} = 2'b11;
            fa = 0;
            fb = 0;
        end else if (frz) begin
            {e_sf, e_sd, e_se, e_sm} = 4'b1111;
            {e_fd, e_fe} = 2'b00;
        end else begin
            e_sf = lw; e_sd = lw; e_se = 1'b0; e_sm = 1'b0;
            e_fd = hz.pcsrcE;
            e_fe = lw || hz.pcsrcE;
        end
        chk("stallF", 32'(hz.stallF), 32'(e_sf));
        chk("stallD", 32'(hz.stallD), 32'(e_sd));
        chk("stallE", 32'(hz.stallE), 32'(e_se));
        chk("stallM", 32'(hz.stallM), 32'(e_sm));
        chk("flushD", 32'(hz.flushD), 32'(e_fd));
        chk("flushE", 32'(hz.flushE), 32'(e_fe));
        chk("forwardAE", 32'(hz.forwardAE), 32'(fa));
        chk("forwardBE", 32'(hz.forwardBE), 32'(fb));
        if (m_valid) begin
            chk("mem_err", 32'(hz.mem_err), 32'(m_err));
            chk("stall_cnt", 32'(hz.stall_cnt), 32'(m_stall));
            chk("flush_cnt", 32'(hz.flush_cnt), 32'(m_flush));
        end
        obs_stallF    = hz.stallF;
        obs_stallM    = hz.stallM;
        obs_flushE    = hz.flushE;
        obs_mem_err   = hz.mem_err;
        obs_stall_cnt = int'(hz.stall_cnt);
        obs_flush_cnt = int'(hz.flush_cnt);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b1;
            m_wait = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        end else begin
            m_err = tmo;
            if (e_sf && m_stall < c_cnt_max) m_stall++;
            if (e_fe && m_flush < c_cnt_max) m_flush++;
            if (!m_wait) begin
                if (hz.mem_req && !hz.mem_ready) begin
                    m_wait = 1'b1;
                    m_waited = 0;
                end
            end else if (hz.mem_ready || tmo) begin
                m_wait = 1'b0;
            end else begin
                m_waited++;
            end
        end
        #1;
    endtask

    initial begin
        int n_frz, n_fl, first_run, n_err, err_at, base_s, base_f;

        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        set_idle();
        cycle();

        // Forwarding priority
        hz.Rs1E = 5'd5; hz.RdM = 5'd5; hz.regwriteM = 1'b1; hz.RdW = 5'd5; hz.regwriteW = 1'b1;
        cycle();
        hz.regwriteM = 1'b0;
        cycle();
        hz.RdW = 5'd0;
        cycle();

        // Load-use: one stall cycle, both counters step by one
        set_idle();
        cycle();
        base_s = obs_stall_cnt;
        base_f = obs_flush_cnt;
        hz.resultsrcE = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        cycle();
        set_idle();
        cycle();
        chk("lu_stall_inc", 32'(obs_stall_cnt - base_s), 32'd1);
        chk("lu_flush_inc", 32'(obs_flush_cnt - base_f), 32'd1);
        hz.resultsrcE = 1'b1; hz.RdE = 5'd0; hz.Rs2D = 5'd0;
        cycle();

        // Branch
        set_idle();
        hz.pcsrcE = 1'b1;
        cycle();

        // Memory wait with a branch held throughout
        set_idle();
        hz.mem_req = 1'b1; hz.pcsrcE = 1'b1;
        n_frz = 0; n_fl = 0;
        for (int i = 0; i < 4; i++) begin
            hz.mem_ready = (i == 3);
            cycle();
            n_frz += int'(obs_stallM);
            n_fl  += int'(obs_flushE);
        end
        chk("wait_frozen", 32'(n_frz), 32'd3);
        chk("wait_flush", 32'(n_fl), 32'd1);
        set_idle();
        cycle();
        chk("wait_run", 32'(obs_stallM), 32'd0);

        // Timeout: memory never ready
        set_idle();
        hz.mem_req = 1'b1;
        first_run = -1; n_err = 0; err_at = -1;
        for (int i = 0; i < 21; i++) begin
            cycle();
            if (!obs_stallM && first_run < 0) first_run = i;
            if (obs_mem_err) begin
                n_err++;
                if (err_at < 0) err_at = i;
            end
        end
        chk("tmo_unfreeze", 32'(first_run), 32'(c_tmo_lim + 1));
        chk("tmo_pulses", 32'(n_err), 32'd1);
        chk("tmo_err_cycle", 32'(err_at), 32'(c_tmo_lim + 2));

        // Reset in the middle of a wait
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b1;
        cycle();
        set_idle();
        cycle();
        chk("rst_stall_cnt", 32'(obs_stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(obs_flush_cnt), 32'd0);
        chk("rst_mem_err", 32'(obs_mem_err), 32'd0);
        chk("rst_run", 32'(obs_stallF), 32'd0);

        // Saturation
        hz.resultsrcE = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
        for (int i = 0; i < 20; i++) cycle();
        set_idle();
        cycle();
        chk("stall_sat", 32'(obs_stall_cnt), 32'(c_cnt_max));

        // Random traffic: fast memory, then slow memory to reach timeouts
        for (int i = 0; i < 400; i++) begin
            rand_inputs(0);
            hz.mem_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        for (int i = 0; i < 400; i++) begin
            rand_inputs(20);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline sequencing controller for the five-stage RV32I core. It generates per-stage stall and flush commands (including `flushE` into the execute-stage register) and operand-forwarding selects for the E stage. A small FSM freezes the whole pipeline while a data-memory access waits for `mem_ready`, with a timeout watchdog. It also keeps saturating performance counters for stall and flush cycles. It sits beside the datapath and drives the enables and flushes of every pipeline register.

## Interface
Parameters:
- `ADW`, 5, register-address width
- `TMO_W`, 4, width of the memory-wait timeout counter; timeout fires after 2**TMO_W − 1 wait cycles
- `CNT_W`, 32, width of each performance counter

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `Rs1D`, `Rs2D`  in  ADW  source registers of the instruction in D
- `Rs1E`, `Rs2E`, `RdE`  in  ADW  source and destination registers in E
- `resultsrcE`  in  1  E instruction is a load
- `pcsrcE`  in  1  taken branch or jump resolved in E
- `RdM`, `RdW`  in  ADW  destinations in M and W
- `regwriteM`, `regwriteW`  in  1  M and W write the register file
- `mem_req`  in  1  M-stage instruction accesses data memory
- `mem_ready`  in  1  data memory completes the access this cycle
- `stallF`, `stallD`, `stallE`, `stallM`  out  1  hold the corresponding pipeline register
- `flushD`, `flushE`  out  1  clear the D and E pipeline registers
- `forwardAE`, `forwardBE`  out  2  `fwd_sel_t` source select for E operands A and B
- `mem_err`  out  1  one-cycle pulse on memory-wait timeout
- `stall_cnt`, `flush_cnt`  out  CNT_W  saturating performance counters

## Operation
- **Forwarding** (combinational), shown for operand A; B is identical with `Rs2E`:
  - `FWD_M` (2'b10) if `regwriteM` && `RdM`≠0 && `RdM`==`Rs1E`.
  - Otherwise `FWD_W` (2'b01) if `regwriteW` && `RdW`≠0 && `RdW`==`Rs1E`.
  - Otherwise `FWD_NONE` (2'b00).
  - M has priority over W.
- **Load-use:** `lwstall` = `resultsrcE` && `RdE`≠0 && (`RdE`==`Rs1D` || `RdE`==`Rs2D`).
- **Branch:** `pcsrcE` asserts `flushD` and `flushE`.
- `lwstall` and `pcsrcE` cannot occur together, because a load never branches. No priority between them is defined.
- **FSM** states are `RUN` and `MEM_WAIT`:
  - `RUN` → `MEM_WAIT` when `mem_req` && !`mem_ready`.
  - `MEM_WAIT` → `RUN` when `mem_ready` or on timeout.
- **Freeze:** `freeze` = (`RUN` && `mem_req` && !`mem_ready`) || (`MEM_WAIT` && !`mem_ready` && !timeout).
- **While `freeze`:**
  - `stallF`, `stallD`, `stallE` and `stallM` are all 1.
  - `flushD` = `flushE` = 0. A pending `pcsrcE` or `lwstall` is held in place and acted on in the first unfrozen cycle.
- **While not frozen:**
  - `stallF` = `stallD` = `lwstall`.
  - `flushE` = `lwstall` || `pcsrcE`.
  - `flushD` = `pcsrcE`.
  - `stallE` = `stallM` = 0.
- **Wait counter:**
  - Cleared on entry to `MEM_WAIT`.
  - Increments each `MEM_WAIT` cycle.
  - Timeout = counter at all-ones while still in `MEM_WAIT` without `mem_ready`. That cycle raises `mem_err` for one cycle, drops the freeze, and returns the FSM to `RUN`.
- **Counters** saturate at all-ones, never wrap, and increment by at most 1 per cycle:
  - `stall_cnt` increments in any cycle with `stallF` asserted.
  - `flush_cnt` increments in any cycle with `flushE` asserted.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs plus FSM state, with zero latency.
- FSM state, wait counter, `mem_err` and the performance counters are registered.
- **Reset** (synchronous, takes priority over all other logic):
  - Next state is `RUN`; wait counter, `stall_cnt`, `flush_cnt` and `mem_err` all go to 0.
  - While `rst` is high, the combinational outputs are forced to `flushD` = `flushE` = 1, all stalls 0, forwards `FWD_NONE`.
- Reset during `MEM_WAIT` returns the FSM to `RUN` on the next edge, with no `mem_err`.
- `mem_ready` in the same cycle as `mem_req` means no freeze and no state change.
- `mem_ready` together with timeout means the ready wins and `mem_err` stays 0.
- After leaving `MEM_WAIT`, `mem_req` may reassert immediately. A back-to-back wait re-enters `MEM_WAIT` with the counter cleared.

## Structure
- Add to `rv32i_pkg`:
  - `fwd_sel_t` (`FWD_NONE`, `FWD_W`, `FWD_M`), 2 bits.
  - `hz_state_t` (`RUN`, `MEM_WAIT`).
- One sub-module, `sat_counter` (parameter `W`; ports `clk`, `rst`, `inc`, `cnt`), instantiated twice for the performance counters.
- Everything else lives in `hazard_controller`.

## Test plan
- **Forwarding priority:** `Rs1E`=5, `RdM`=5, `regwriteM`=1, `RdW`=5, `regwriteW`=1 → `forwardAE`=2'b10. Then `regwriteM`=0 → 2'b01. Then `RdW`=0 → 2'b00.
- **Load-use:** `resultsrcE`=1, `RdE`=7, `Rs2D`=7 → `stallF`=`stallD`=`flushE`=1 and `flushD`=0, for exactly one cycle; `stall_cnt` and `flush_cnt` increase by 1. With `RdE`=0 → no stall.
- **Branch:** `pcsrcE`=1 → `flushD`=`flushE`=1 and no stalls.
- **Memory wait:** `mem_req`=1, `mem_ready` low for 3 cycles then high → all four stalls high for 3 cycles and no flush. A `pcsrcE` held high throughout yields `flushD`/`flushE` only in the ready cycle. FSM is back in `RUN`.
- **Timeout:** `TMO_W`=4, `mem_ready` never asserted → `mem_err` pulses once, 15 cycles after entry to `MEM_WAIT`, and the freeze drops that cycle. A separate case asserts `rst` mid-wait → `RUN`, counters 0, no `mem_err`.
- **Saturation:** with `CNT_W`=4, hold `lwstall` for 20 cycles → `stall_cnt` stops at 15.
